// File: rtl/l1_spike_trace_if.sv
// Spike-in / trace-out bundle between the L1 layer, this trace block and L2.
// The slave modport is the trace block; the master modport is the L1 side.
interface l1_spike_trace_if #(
  parameter int p_width = 9
);
  logic [6:1]                 i_spike;
  logic                       i_clear;
  logic [6*(p_width+1)-1:0]   o_tr;
  logic                       o_event_valid;
  logic [2:0]                 o_event_idx;
  logic                       o_multi;
  logic                       o_tick;

  modport master (
    output i_spike, i_clear,
    input  o_tr, o_event_valid, o_event_idx, o_multi, o_tick
  );

  modport slave (
    input  i_spike, i_clear,
    output o_tr, o_event_valid, o_event_idx, o_multi, o_tick
  );
endinterface

// File: rtl/l1_spike_trace.sv
// Per-neuron decaying time-surface traces for the six L1 spikes, plus a registered event summary.
// Define TRACE_EXP_DECAY_EN for geometric decay (trace >> p_shift, min 1); default is linear decay.
module l1_spike_trace #(
  parameter int p_width      = 9,
  parameter int p_n          = 6,
  parameter int p_decay_div  = 16,
  parameter int p_decay_step = 4,
  parameter int p_shift      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  l1_spike_trace_if.slave   bus
);

  localparam int TW = p_width + 1;
  localparam logic [TW-1:0] TR_MAX = '1;
  localparam logic [TW-1:0] STEP   = TW'(p_decay_step);
  localparam logic [15:0]   CNT_TC = 16'(p_decay_div - 1);

  if (p_n != 6 || p_decay_div < 1 || p_decay_div > 65535 || p_shift < 0) begin : g_bad_cfg
    $error("l1_spike_trace: unsupported parameter set");
  end

  logic [15:0]   cnt_q, cnt_d;
  logic          tick;
  logic          tick_q;
  logic [TW-1:0] tr_q [1:6];
  logic [TW-1:0] tr_d [1:6];
  logic          valid_q, valid_d;
  logic [2:0]    idx_q, idx_d;
  logic          multi_q, multi_d;

  function automatic logic [TW-1:0] f_decay(input logic [TW-1:0] tr);
    logic [TW-1:0] dec;
`ifdef TRACE_EXP_DECAY_EN
    dec = tr >> p_shift;
    if (dec == '0) dec = TW'(1);
    return tr - dec;
`else
    dec = STEP;
    if (tr <= dec) return '0;
    return tr - dec;
`endif
  endfunction

  assign tick = (cnt_q == CNT_TC);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (bus.i_clear || tick) cnt_d = '0;
  end

  // Clear beats spike, spike beats decay; lanes are independent.
  always_comb begin
    for (int k = 1; k <= 6; k++) begin
      tr_d[k] = tr_q[k];
      if (bus.i_clear)
        tr_d[k] = '0;
      else if (bus.i_spike[k])
        tr_d[k] = TR_MAX;
      else if (tick && (tr_q[k] != '0))
        tr_d[k] = f_decay(tr_q[k]);
    end
  end

  always_comb begin
    valid_d = |bus.i_spike;
    multi_d = (bus.i_spike & (bus.i_spike - 6'd1)) != 6'd0;
    idx_d   = '0;
    for (int k = 6; k >= 1; k--) begin
      if (bus.i_spike[k]) idx_d = 3'(k);
    end
    if (bus.i_clear) begin
      valid_d = 1'b0;
      multi_d = 1'b0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      multi_q <= 1'b0;
      for (int k = 1; k <= 6; k++) tr_q[k] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
      for (int k = 1; k <= 6; k++) tr_q[k] <= tr_d[k];
    end
  end

  for (genvar g = 1; g <= 6; g++) begin : g_pack
    assign bus.o_tr[(g-1)*TW +: TW] = tr_q[g];
  end

  assign bus.o_event_valid = valid_q;
  assign bus.o_event_idx   = idx_q;
  assign bus.o_multi       = multi_q;
  assign bus.o_tick        = tick_q;

endmodule

// File: tb/tb_l1_spike_trace.sv
// Directed bench for l1_spike_trace: reset/idle, linear or exponential decay, collisions,
// spike/tick/clear priority and asynchronous reset.
module tb_l1_spike_trace;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  l1_spike_trace_if #(.p_width(9)) bus ();

  l1_spike_trace #(
    .p_width(9), .p_n(6), .p_decay_div(16), .p_decay_step(4), .p_shift(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

`ifdef TRACE_EXP_DECAY_EN
  localparam int EXP_1TICK  = 960;
  localparam int EXP_2TICK  = 900;
`else
  localparam int EXP_1TICK  = 1019;
  localparam int EXP_2TICK  = 1015;
`endif

  function automatic int lane(input int k);
    return int'(bus.o_tr[(k-1)*10 +: 10]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.i_clear = 1'b1;
    bus.i_spike = 6'b0;
    cyc(1);
    bus.i_clear = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    int last;
    int bad_gap;
    int bad_idle;
    bus.i_spike = 6'b0;
    bus.i_clear = 1'b0;
    #23;
    n_vec++;
    if (bus.o_tr !== '0 || bus.o_event_valid !== 1'b0 || bus.o_event_idx !== 3'd0 ||
        bus.o_multi !== 1'b0 || bus.o_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: tr=%h valid=%b idx=%0d multi=%b tick=%b, required all 0",
               bus.o_tr, bus.o_event_valid, bus.o_event_idx, bus.o_multi, bus.o_tick);
    end
    @(negedge clk) rst_n = 1'b1;
    pulses = 0; last = 0; bad_gap = 0; bad_idle = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(1);
      if (bus.o_tr !== '0 || bus.o_event_valid !== 1'b0) bad_idle++;
      if (bus.o_tick === 1'b1) begin
        pulses++;
        if (i - last != 16) bad_gap++;
        last = i;
      end
    end
    n_vec++;
    if (bad_idle != 0) begin
      n_err++;
      $display("FAIL idle_outputs: %0d cycles with nonzero trace/valid, required 0", bad_idle);
    end
    n_vec++;
    if (pulses != 6) begin
      n_err++;
      $display("FAIL idle_tick_count: %0d pulses in 100 cycles, required 6", pulses);
    end
    n_vec++;
    if (bad_gap != 0) begin
      n_err++;
      $display("FAIL idle_tick_period: %0d gaps not equal to 16, required 0", bad_gap);
    end
  endtask

  task automatic test_single_spike();
    do_clear();                       // edge E0: prescaler at 0
    bus.i_spike = 6'b000100;
    cyc(1);                           // E1
    bus.i_spike = 6'b0;
    n_vec++;
    if (lane(3) != 1023 || bus.o_event_valid !== 1'b1 || bus.o_event_idx !== 3'd3 ||
        bus.o_multi !== 1'b0) begin
      n_err++;
      $display("FAIL single_load: lane3=%0d valid=%b idx=%0d multi=%b, required 1023 1 3 0",
               lane(3), bus.o_event_valid, bus.o_event_idx, bus.o_multi);
    end
    n_vec++;
    if (lane(1) != 0 || lane(2) != 0 || lane(4) != 0 || lane(5) != 0 || lane(6) != 0) begin
      n_err++;
      $display("FAIL single_others: tr=%h, required only lane3 set", bus.o_tr);
    end
`ifndef TRACE_EXP_DECAY_EN
    cyc(79);                          // E80: five ticks applied
    n_vec++;
    if (lane(3) != 1003) begin
      n_err++;
      $display("FAIL linear_5_ticks: lane3=%0d, required 1003", lane(3));
    end
    cyc(255*16 - 80);                 // E4080: 255 ticks
    n_vec++;
    if (lane(3) != 3) begin
      n_err++;
      $display("FAIL linear_255_ticks: lane3=%0d, required 3", lane(3));
    end
    cyc(16);                          // 256 ticks
    n_vec++;
    if (lane(3) != 0) begin
      n_err++;
      $display("FAIL linear_saturate: lane3=%0d, required 0", lane(3));
    end
    cyc(16);
    n_vec++;
    if (lane(3) != 0) begin
      n_err++;
      $display("FAIL linear_no_wrap: lane3=%0d, required 0", lane(3));
    end
`endif
  endtask

  task automatic test_collision();
    do_clear();
    bus.i_spike = 6'b000101;
    cyc(1);
    n_vec++;
    if (bus.o_event_idx !== 3'd1 || bus.o_multi !== 1'b1 || bus.o_event_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pair_event: idx=%0d multi=%b valid=%b, required 1 1 1",
               bus.o_event_idx, bus.o_multi, bus.o_event_valid);
    end
    bus.i_spike = 6'b101010;
    cyc(1);
    bus.i_spike = 6'b0;
    n_vec++;
    if (bus.o_event_idx !== 3'd2 || bus.o_multi !== 1'b1 || bus.o_event_valid !== 1'b1) begin
      n_err++;
      $display("FAIL collision_event: idx=%0d multi=%b valid=%b, required 2 1 1",
               bus.o_event_idx, bus.o_multi, bus.o_event_valid);
    end
    n_vec++;
    if (lane(2) != 1023 || lane(4) != 1023 || lane(6) != 1023) begin
      n_err++;
      $display("FAIL collision_load: lanes2/4/6=%0d/%0d/%0d, required 1023 each",
               lane(2), lane(4), lane(6));
    end
    n_vec++;
    if (lane(1) != 1023 || lane(3) != 1023 || lane(5) != 0) begin
      n_err++;
      $display("FAIL collision_hold: lanes1/3/5=%0d/%0d/%0d, required 1023/1023/0",
               lane(1), lane(3), lane(5));
    end
    cyc(1);
    n_vec++;
    if (bus.o_event_valid !== 1'b0 || bus.o_event_idx !== 3'd0 || bus.o_multi !== 1'b0) begin
      n_err++;
      $display("FAIL no_spike_event: valid=%b idx=%0d multi=%b, required 0 0 0",
               bus.o_event_valid, bus.o_event_idx, bus.o_multi);
    end
  endtask

  task automatic test_spike_tick_clear();
    do_clear();                       // E0
    bus.i_spike = 6'b000011;
    cyc(1);                           // E1
    bus.i_spike = 6'b0;
    cyc(15);                          // E16: first tick
    n_vec++;
    if (lane(1) != EXP_1TICK || lane(2) != EXP_1TICK) begin
      n_err++;
      $display("FAIL first_tick: lane1=%0d lane2=%0d, required %0d", lane(1), lane(2), EXP_1TICK);
    end
    cyc(15);                          // E31
    bus.i_spike = 6'b000001;
    cyc(1);                           // E32: spike coincides with tick
    bus.i_spike = 6'b0;
    n_vec++;
    if (lane(1) != 1023) begin
      n_err++;
      $display("FAIL spike_beats_tick: lane1=%0d, required 1023", lane(1));
    end
    n_vec++;
    if (lane(2) != EXP_2TICK) begin
      n_err++;
      $display("FAIL second_tick: lane2=%0d, required %0d", lane(2), EXP_2TICK);
    end
    cyc(7);                           // E39, prescaler mid-period
    bus.i_clear = 1'b1;
    bus.i_spike = 6'b000001;
    cyc(1);                           // E40
    bus.i_clear = 1'b0;
    bus.i_spike = 6'b0;
    n_vec++;
    if (bus.o_tr !== '0 || bus.o_event_valid !== 1'b0 || bus.o_event_idx !== 3'd0 ||
        bus.o_multi !== 1'b0) begin
      n_err++;
      $display("FAIL clear_beats_spike: tr=%h valid=%b idx=%0d multi=%b, required all 0",
               bus.o_tr, bus.o_event_valid, bus.o_event_idx, bus.o_multi);
    end
    cyc(8);                           // E48: old schedule would tick here
    n_vec++;
    if (bus.o_tick !== 1'b0) begin
      n_err++;
      $display("FAIL clear_restart_early: o_tick=%b, required 0", bus.o_tick);
    end
    cyc(8);                           // E56: 16 cycles after clear
    n_vec++;
    if (bus.o_tick !== 1'b1) begin
      n_err++;
      $display("FAIL clear_restart_tick: o_tick=%b, required 1", bus.o_tick);
    end
  endtask

`ifdef TRACE_EXP_DECAY_EN
  task automatic test_exp_decay();
    int exp_v;
    int dec;
    int ticks;
    do_clear();
    bus.i_spike = 6'b010000;
    cyc(1);
    bus.i_spike = 6'b0;
    exp_v = 1023;
    ticks = 0;
    while (exp_v != 0 && ticks < 200) begin
      cyc(16);
      dec = exp_v >> 4;
      if (dec == 0) dec = 1;
      exp_v = exp_v - dec;
      ticks++;
      n_vec++;
      if (lane(5) != exp_v) begin
        n_err++;
        $display("FAIL exp_tick_%0d: lane5=%0d, required %0d", ticks, lane(5), exp_v);
      end
    end
    cyc(16);
    n_vec++;
    if (lane(5) != 0) begin
      n_err++;
      $display("FAIL exp_no_wrap: lane5=%0d, required 0", lane(5));
    end
  endtask
`endif

  task automatic test_async_reset();
    do_clear();
    bus.i_spike = 6'b111111;
    cyc(1);
    bus.i_spike = 6'b0;
    n_vec++;
    if (lane(1) != 1023 || lane(6) != 1023 || bus.o_event_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_load: lane1=%0d lane6=%0d valid=%b, required 1023 1023 1",
               lane(1), lane(6), bus.o_event_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.o_tr !== '0 || bus.o_event_valid !== 1'b0 || bus.o_event_idx !== 3'd0 ||
        bus.o_multi !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: tr=%h valid=%b idx=%0d multi=%b, required all 0",
               bus.o_tr, bus.o_event_valid, bus.o_event_idx, bus.o_multi);
    end
    @(negedge clk) rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    bus.i_spike = 6'b0;
    bus.i_clear = 1'b0;
    test_reset();
    test_single_spike();
    test_collision();
    test_spike_tick_clear();
`ifdef TRACE_EXP_DECAY_EN
    test_exp_decay();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l1_spike_trace.md
Name: l1_spike_trace

Overview:
- Downstream neighbour of the L1 layer. Consumes L1's six output spikes and turns each into a decaying per-neuron time-surface trace.
- Packed traces feed the L2 layer and are looped back as the L1 trainer's trace input.
- Also emits a registered single-event summary (valid, winner index, collision flag) for the L2 input stage.

Parameters:
- p_width, 9: base data width; each trace is p_width+1 bits.
- p_n, 6: number of L1 neurons and trace lanes; fixed at 6 for this design.
- p_decay_div, 16: decay prescaler period in clock cycles; legal range 1..2^16-1.
- p_decay_step, 4: linear decrement applied per decay tick.
- p_shift, 4: exponential decay shift; used only when TRACE_EXP_DECAY_EN is defined.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_spike  in  [6:1]  L1 spike vector; bit k = neuron k fired this cycle.
- i_clear  in  1  synchronous clear of traces and prescaler (sample / epoch boundary).
- o_tr  out  [6*(p_width+1)-1:0]  packed traces; neuron k occupies bits [k*(p_width+1)-1 : (k-1)*(p_width+1)].
- o_event_valid  out  1  at least one spike was seen in the previous cycle.
- o_event_idx  out  [2:0]  winning neuron index (1..6); 0 when not valid.
- o_multi  out  1  more than one spike bit was set in the previous cycle.
- o_tick  out  1  registered decay tick strobe.

Behaviour:
- Reset (async, i_rst_n=0): all traces 0, prescaler 0, o_event_valid 0, o_event_idx 0, o_multi 0, o_tick 0.
- TR_MAX = 2^(p_width+1)-1 (1023 for p_width=9).
- Prescaler:
  - cnt runs 0..p_decay_div-1.
  - tick is asserted combinationally when cnt == p_decay_div-1; cnt then wraps to 0.
  - p_decay_div=1 gives a tick every cycle.
  - o_tick is tick registered, so it lags by 1 cycle.
- Per-lane trace update, priority highest first:
  1. i_clear: trace <= 0.
  2. i_spike[k]: trace <= TR_MAX. A spike beats a tick in the same cycle.
  3. tick and trace != 0: trace <= trace - p_decay_step, saturating at 0 (never wraps).
  4. Otherwise hold.
- i_clear also forces cnt to 0 and clears o_event_valid, o_event_idx and o_multi in the next cycle, even if spikes are present.
- Latency:
  - Spike at cycle n: o_tr lane = TR_MAX at n+1.
  - Tick at cycle n: decremented value visible at n+1.
- Event summary, registered at 1-cycle latency:
  - o_event_valid = |i_spike.
  - o_event_idx = lowest set index (neuron 1 has highest priority).
  - o_multi = popcount(i_spike) > 1.
  - With no spikes, idx = 0 and multi = 0.
- Respiking lanes: a lane that is already nonzero and spikes again reloads to TR_MAX. No accumulation.
- Lanes update independently; multiple simultaneous spikes load all of their lanes.
- Reset asserted mid-decay: immediate clear, with no partial update.
- o_tr is a pure register output; no combinational path from i_spike.

Optional Feature:
- Macro: TRACE_EXP_DECAY_EN.
- Defined: on tick, trace <= trace - max(trace >> p_shift, 1) for trace != 0. This gives geometric decay that still reaches 0. p_decay_step is ignored.
- Not defined: linear saturating decrement by p_decay_step as above.
- Prescaler, priorities and latency are identical in both builds.

Test Plan:
- Reset / idle: hold i_rst_n=0, release, no spikes for 100 cycles -> all o_tr lanes 0, o_event_valid 0, o_tick pulses every 16 cycles.
- Single spike, linear build (defaults): i_spike=6'b000100 at cycle n -> at n+1 lane 3 = 1023, o_event_valid=1, o_event_idx=3, o_multi=0. After 5 ticks lane 3 = 1003; after 256 ticks it saturates at 0, never wraps.
- Collision: i_spike=6'b101010 in one cycle -> lanes 2, 4, 6 = 1023, o_event_idx=2, o_multi=1; lanes 1, 3, 5 unchanged.
- Spike vs tick vs clear: spike on lane 1 coincident with a tick -> lane 1 = 1023, not 1019. i_clear with i_spike=6'b000001 -> lane 1 = 0, o_event_valid=0, prescaler restarts (next o_tick 16 cycles later).
- Exponential build (TRACE_EXP_DECAY_EN, p_shift=4): lane at 1023, one tick -> 1023-63 = 960. Lane at 10, one tick -> 9 (minimum decrement 1). Lane at 1, one tick -> 0.
- Async reset mid-operation: lanes nonzero, assert i_rst_n=0 between clock edges -> o_tr is 0 immediately, with no clock edge required.
